// File: rtl/sign_apply_serial_if.sv
// sign_apply_serial_if: handshake bundle for the digit-serial sign-apply unit.
//   Upstream side : InValid, InReady, Mag, Neg
//   Downstream    : OutValid, OutReady, Z, Ovf
// master = the environment driving operands and consuming results,
// slave  = the sign_apply_serial block itself.
interface sign_apply_serial_if #(parameter int width = 8);
  logic             InValid;
  logic             InReady;
  logic [width-1:0] Mag;
  logic             Neg;
  logic             OutValid;
  logic             OutReady;
  logic [width-1:0] Z;
  logic             Ovf;

  modport master (output InValid, Mag, Neg, OutReady,
                  input  InReady, OutValid, Z, Ovf);
  modport slave  (input  InValid, Mag, Neg, OutReady,
                  output InReady, OutValid, Z, Ovf);
endinterface

// File: rtl/sign_apply_serial.sv
// sign_apply_serial: digit-serial sign-magnitude -> two's complement.
//   Z = Neg ? -Mag : Mag (mod 2^width), DW bits per cycle, LSB first.
//   -Mag is formed as ~Mag + 1: each digit is conditionally inverted and the
//   carry register, seeded with Neg, supplies the +1 and ripples between digits.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous reset, active high
//   io   - sign_apply_serial_if.slave (InValid/InReady/Mag/Neg in,
//          OutValid/OutReady/Z/Ovf out)
// Parameters: width >= 2, DW must divide width (DW = width -> one cycle).
module sign_apply_serial #(
  parameter int width = 8,
  parameter int DW    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  sign_apply_serial_if.slave io
);
  localparam int ND = width / DW;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    state, nstate;
  logic [ND-1:0][DW-1:0]     mag_q;
  logic [ND-1:0][DW-1:0]     z_q;
  logic                      neg_q;
  logic                      carry_q;
  logic [CW-1:0]             cnt_q;
  logic                      ovf_q;
  logic                      ov_q;

  logic                      accept;
  logic                      last;
  logic [DW:0]               sum;

  // Only one operation in flight: ready in IDLE, or in DONE when the result
  // leaves on this same edge.
  assign io.InReady = !RST && ((state == IDLE) || (state == DONE && io.OutReady));
  assign accept     = io.InValid && io.InReady;
  assign last       = (cnt_q == CW'(ND - 1));

  // One DW-bit slice of the conditional-complement adder.
  assign sum = {1'b0, mag_q[cnt_q] ^ {DW{neg_q}}} + {{DW{1'b0}}, carry_q};

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (accept) nstate = BUSY;
      BUSY: if (last)   nstate = DONE;
      DONE: if (io.OutReady) nstate = accept ? BUSY : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      mag_q   <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state <= nstate;
      ov_q  <= (nstate == DONE);
      if (accept) begin
        mag_q   <= io.Mag;
        neg_q   <= io.Neg;
        carry_q <= io.Neg;
        cnt_q   <= '0;
        // -Mag fits only up to 2^(width-1); +Mag only below it.
        ovf_q   <= io.Neg ? (io.Mag[width-1] & (|io.Mag[width-2:0]))
                          : io.Mag[width-1];
      end else if (state == BUSY) begin
        z_q[cnt_q] <= sum[DW-1:0];
        carry_q    <= sum[DW];   // final carry-out simply dies here
        cnt_q      <= cnt_q + 1'b1;
      end
    end
  end

  assign io.Z        = z_q;
  assign io.Ovf      = ovf_q;
  assign io.OutValid = ov_q;

endmodule
